// File: rtl/zxbus_responder_if.sv
// rtl/zxbus_responder_if.sv - ZX-bus I/O signal bundle between a Z80-side master and the responder
//
// Ports (signals):
//   iorq_n, m1_n, rd_n, wr_n  Z80 strobes, driven by master, asynchronous to fclk
//   a[15:0]                   Z80 address, stable while iorq_n is low
//   d_in[7:0]                 data bus as seen by the device
//   d_out[7:0], d_oe          read data and its output enable, driven by responder
//   iorqge                    port-claimed indication, driven by responder
//   wait_n                    Z80 WAIT_n, 1 = released, driven by responder
interface zxbus_responder_if;
    logic        iorq_n;
    logic        m1_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        iorqge;
    logic        wait_n;

    modport master (
        output iorq_n, m1_n, rd_n, wr_n, a, d_in,
        input  d_out, d_oe, iorqge, wait_n
    );

    modport slave (
        input  iorq_n, m1_n, rd_n, wr_n, a, d_in,
        output d_out, d_oe, iorqge, wait_n
    );
endinterface

// File: rtl/zxbus_responder.sv
// rtl/zxbus_responder.sv - ZX-bus I/O port responder with IORQGE claim, WAIT_n stretch and 4-entry register file
//
// Parameters:
//   PORT_LO      low address byte selecting the device
//   WAIT_CYCLES  fclk cycles WAIT_n is held low per claimed cycle (0..15)
// Ports:
//   fclk   system clock
//   rst_n  asynchronous active-low reset
//   bus    zxbus_responder_if.slave: Z80 strobes/address/data in, d_out/d_oe/iorqge/wait_n out
// Register map (index a[9:8]): R0..R2 read/write, R3 read-only count of accepted writes to R0..R2.
module zxbus_responder #(
    parameter logic [7:0] PORT_LO     = 8'h57,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic              fclk,
    input  logic              rst_n,
    zxbus_responder_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACCESS,
        S_HOLD,
        S_MISS
    } state_t;

    state_t      state, state_nxt;

    logic [1:0]  iorq_q, m1_q, rd_q, wr_q;
    logic        iorq_s, m1_s, rd_s, wr_s;
    logic [1:0]  fill;
    logic        armed;

    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  d_out, d_out_nxt;
    logic        d_oe, d_oe_nxt;
    logic        iorqge, iorqge_nxt;
    logic        wait_n, wait_n_nxt;
    logic [7:0]  r0, r1, r2, r0_nxt, r1_nxt, r2_nxt;
    logic [7:0]  wcount, wcount_nxt;

    logic        hit;
    logic [1:0]  idx;
    logic [7:0]  rd_data;
    logic        unused_addr;

    assign iorq_s = iorq_q[1];
    assign m1_s   = m1_q[1];
    assign rd_s   = rd_q[1];
    assign wr_s   = wr_q[1];

    assign hit         = (bus.a[7:0] == PORT_LO);
    assign idx         = bus.a[9:8];
    assign unused_addr = ^bus.a[15:10];

    always_comb begin
        rd_data = wcount;
        case (idx)
            2'd0:    rd_data = r0;
            2'd1:    rd_data = r1;
            2'd2:    rd_data = r2;
            default: rd_data = wcount;
        endcase
    end

    // Synchronizers plus arming. The stages reset to 1, which says nothing about
    // the real bus, so arming waits until `fill` shows the pipeline holds sampled
    // data; a cycle already running at reset release is then never claimed.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            iorq_q <= 2'b11;
            m1_q   <= 2'b11;
            rd_q   <= 2'b11;
            wr_q   <= 2'b11;
            fill   <= 2'b00;
            armed  <= 1'b0;
        end else begin
            iorq_q <= {iorq_q[0], bus.iorq_n};
            m1_q   <= {m1_q[0], bus.m1_n};
            rd_q   <= {rd_q[0], bus.rd_n};
            wr_q   <= {wr_q[0], bus.wr_n};
            fill   <= {fill[0], 1'b1};
            if (fill[1] && iorq_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            d_out  <= 8'd0;
            d_oe   <= 1'b0;
            iorqge <= 1'b0;
            wait_n <= 1'b1;
            r0     <= 8'd0;
            r1     <= 8'd0;
            r2     <= 8'd0;
            wcount <= 8'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            d_out  <= d_out_nxt;
            d_oe   <= d_oe_nxt;
            iorqge <= iorqge_nxt;
            wait_n <= wait_n_nxt;
            r0     <= r0_nxt;
            r1     <= r1_nxt;
            r2     <= r2_nxt;
            wcount <= wcount_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        d_out_nxt  = d_out;
        d_oe_nxt   = d_oe;
        iorqge_nxt = iorqge;
        wait_n_nxt = wait_n;
        r0_nxt     = r0;
        r1_nxt     = r1;
        r2_nxt     = r2;
        wcount_nxt = wcount;

        case (state)
            S_IDLE: begin
                // INTA (m1 low) never leaves IDLE
                if (armed && !iorq_s && m1_s) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (hit && m1_s) begin
                    iorqge_nxt = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt  = S_WAIT;
                        wait_n_nxt = 1'b0;
                        cnt_nxt    = CNT_LOAD;
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end else begin
                    state_nxt = S_MISS;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = S_ACCESS;
                    wait_n_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACCESS: begin
                state_nxt = S_HOLD;
                // read has priority when both strobes are low
                if (!rd_s) begin
                    d_out_nxt = rd_data;
                    d_oe_nxt  = 1'b1;
                end else if (!wr_s && idx != 2'd3) begin
                    case (idx)
                        2'd0:    r0_nxt = bus.d_in;
                        2'd1:    r1_nxt = bus.d_in;
                        default: r2_nxt = bus.d_in;
                    endcase
                    wcount_nxt = wcount + 8'd1;
                end
            end
            S_HOLD: begin
                if (iorq_s) begin
                    state_nxt  = S_IDLE;
                    iorqge_nxt = 1'b0;
                    d_oe_nxt   = 1'b0;
                end
            end
            S_MISS: begin
                iorqge_nxt = 1'b0;
                d_oe_nxt   = 1'b0;
                if (iorq_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.d_out  = d_out;
    assign bus.d_oe   = d_oe;
    assign bus.iorqge = iorqge;
    assign bus.wait_n = wait_n;

endmodule

// File: tb/tb_zxbus_responder.sv
// tb/tb_zxbus_responder.sv - bench for zxbus_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 builds side by side)
module tb_zxbus_responder;

    logic        fclk;
    logic        rst_n;
    logic        iorq_n, m1_n, rd_n, wr_n;
    logic [15:0] a;
    logic [7:0]  d_in;

    int n_checks;
    int n_pass;
    int n_fail;

    logic [7:0] m_reg [3];
    logic [7:0] m_cnt;

    zxbus_responder_if bus_a ();
    zxbus_responder_if bus_b ();

    assign bus_a.iorq_n = iorq_n;
    assign bus_a.m1_n   = m1_n;
    assign bus_a.rd_n   = rd_n;
    assign bus_a.wr_n   = wr_n;
    assign bus_a.a      = a;
    assign bus_a.d_in   = d_in;
    assign bus_b.iorq_n = iorq_n;
    assign bus_b.m1_n   = m1_n;
    assign bus_b.rd_n   = rd_n;
    assign bus_b.wr_n   = wr_n;
    assign bus_b.a      = a;
    assign bus_b.d_in   = d_in;

    zxbus_responder #(.PORT_LO(8'h57), .WAIT_CYCLES(2)) dut_a (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    zxbus_responder #(.PORT_LO(8'h57), .WAIT_CYCLES(0)) dut_b (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
        m_cnt = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] idx);
        if (idx == 2'd3) return m_cnt;
        return m_reg[idx];
    endfunction

    task automatic model_write(input logic [1:0] idx, input logic [7:0] data);
        if (idx != 2'd3) begin
            m_reg[idx] = data;
            m_cnt      = m_cnt + 8'd1;
        end
    endtask

    // One complete Z80 I/O cycle: iorq_n held low for 12 edges, then released.
    // Edge indices count from E0, the first edge sampling iorq_n low.
    task automatic bus_cycle(input bit is_rd, input bit inta, input logic [15:0] addr,
                             input logic [7:0] data);
        int ga, gb, wfa, wla, wlb, oa, ob, ra, rb;
        logic [7:0] da, db, exp_rd;
        bit claim;
        claim  = (addr[7:0] == 8'h57) && !inta;
        exp_rd = model_read(addr[9:8]);
        ga = -1; gb = -1; wfa = -1; wla = 0; wlb = 0; oa = -1; ob = -1; ra = -1; rb = -1;

        @(negedge fclk);
        a      = addr;
        d_in   = data;
        m1_n   = inta ? 1'b0 : 1'b1;
        iorq_n = 1'b0;
        rd_n   = is_rd ? 1'b0 : 1'b1;
        wr_n   = is_rd ? 1'b1 : 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge fclk);
            #1;
            if (bus_a.iorqge === 1'b1 && ga < 0) ga = k;
            if (bus_b.iorqge === 1'b1 && gb < 0) gb = k;
            if (bus_a.wait_n !== 1'b1) begin
                wla++;
                if (wfa < 0) wfa = k;
            end
            if (bus_b.wait_n !== 1'b1) wlb++;
            if (bus_a.d_oe === 1'b1 && oa < 0) oa = k;
            if (bus_b.d_oe === 1'b1 && ob < 0) ob = k;
        end
        da = bus_a.d_out;
        db = bus_b.d_out;

        @(negedge fclk);
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge fclk);
            #1;
            if (bus_a.iorqge === 1'b0 && bus_a.d_oe === 1'b0 && ra < 0) ra = k;
            if (bus_b.iorqge === 1'b0 && bus_b.d_oe === 1'b0 && rb < 0) rb = k;
        end

        if (claim) begin
            chk("claim_edge_a", ga, 3);
            chk("wait_first_a", wfa, 3);
            chk("wait_len_a", wla, 2);
            chk("claim_edge_b", gb, 3);
            chk("wait_len_b", wlb, 0);
            chk("release_a", ra, 2);
            chk("release_b", rb, 2);
            if (is_rd) begin
                chk("doe_edge_a", oa, 6);
                chk("doe_edge_b", ob, 4);
                chk("rdata_a", da, exp_rd);
                chk("rdata_b", db, exp_rd);
            end else begin
                chk("no_doe_on_write_a", oa, -1);
                chk("no_doe_on_write_b", ob, -1);
                model_write(addr[9:8], data);
            end
        end else begin
            chk("no_claim_a", ga, -1);
            chk("no_claim_b", gb, -1);
            chk("no_wait_a", wla, 0);
            chk("no_doe_a", oa, -1);
            chk("no_doe_b", ob, -1);
        end
    endtask

    int seen;
    logic [7:0] lo;
    logic [1:0] ridx;
    int kind;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        model_reset();
        rst_n  = 1'b0;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a      = 16'h0000;
        d_in   = 8'h00;

        repeat (3) @(negedge fclk);
        chk("rst_d_out", bus_a.d_out, 8'h00);
        chk("rst_d_oe", bus_a.d_oe, 1'b0);
        chk("rst_iorqge", bus_a.iorqge, 1'b0);
        chk("rst_wait_n", bus_a.wait_n, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge fclk);

        // write then read R1
        bus_cycle(1'b0, 1'b0, 16'h0157, 8'hA5);
        bus_cycle(1'b1, 1'b0, 16'h0157, 8'h00);
        bus_cycle(1'b1, 1'b0, 16'h0357, 8'h00);
        // miss, then INTA on the device port
        bus_cycle(1'b1, 1'b0, 16'h0158, 8'h00);
        bus_cycle(1'b0, 1'b1, 16'h0157, 8'h77);
        bus_cycle(1'b1, 1'b0, 16'h0157, 8'h00);
        // writes to R3 are ignored and uncounted
        bus_cycle(1'b0, 1'b0, 16'h0357, 8'h12);
        bus_cycle(1'b1, 1'b0, 16'h0357, 8'h00);

        // reset during WAIT of a write, released with iorq_n still low
        @(negedge fclk);
        a      = 16'h0257;
        d_in   = 8'h3C;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        repeat (5) @(posedge fclk);
        #1;
        chk("pre_reset_in_wait", bus_a.wait_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_iorqge", bus_a.iorqge, 1'b0);
        chk("async_rst_wait_n", bus_a.wait_n, 1'b1);
        chk("async_rst_d_out", bus_a.d_out, 8'h00);
        chk("async_rst_d_oe", bus_a.d_oe, 1'b0);
        model_reset();
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge fclk);
            #1;
            if (bus_a.iorqge !== 1'b0 || bus_a.wait_n !== 1'b1 ||
                bus_b.iorqge !== 1'b0 || bus_b.wait_n !== 1'b1) seen++;
        end
        chk("cycle_at_reset_ignored", seen, 0);
        @(negedge fclk);
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        repeat (6) @(posedge fclk);
        bus_cycle(1'b1, 1'b0, 16'h0257, 8'h00);
        bus_cycle(1'b1, 1'b0, 16'h0357, 8'h00);

        // write counter wraps from 0xFF to 0x00
        for (int i = 0; i < 255; i++) begin
            bus_cycle(1'b0, 1'b0, 16'h0057, 8'(i));
        end
        bus_cycle(1'b1, 1'b0, 16'h0357, 8'h00);
        chk("count_ff_model", m_cnt, 8'hFF);
        bus_cycle(1'b0, 1'b0, 16'h0057, 8'h5A);
        bus_cycle(1'b1, 1'b0, 16'h0357, 8'h00);
        bus_cycle(1'b1, 1'b0, 16'h0057, 8'h00);

        // randomized mix of reads, writes, misses and INTA
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            ridx = 2'($urandom_range(0, 3));
            lo   = 8'h57;
            if (kind == 0) begin
                lo = 8'($urandom_range(0, 255));
                if (lo == 8'h57) lo = 8'h58;
            end
            bus_cycle(kind >= 6, kind == 1, {6'($urandom), ridx, lo}, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
